// File: rtl/accum_wr_sequencer_if.sv
// rtl/accum_wr_sequencer_if.sv - request and write-side signal bundle for the accumulator write sequencer
interface accum_wr_sequencer_if #(
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int LAT_WIDTH    = 8
);
  localparam int NUM_SUBMATS_M = MAX_OUT_ROWS / SYS_ARR_ROWS;
  localparam int NUM_SUBMATS_N = MAX_OUT_COLS / SYS_ARR_COLS;
  localparam int M_W           = $clog2(NUM_SUBMATS_M);
  localparam int N_W           = $clog2(NUM_SUBMATS_N);
  localparam int ROW_W         = $clog2(SYS_ARR_ROWS);

  logic                 start;
  logic [M_W-1:0]       submat_m_in;
  logic [N_W-1:0]       submat_n_in;
  logic [LAT_WIDTH-1:0] fill_latency;
  logic                 stall;
  logic                 wr_en;
  logic [ROW_W-1:0]     sub_row;
  logic [M_W-1:0]       submat_m;
  logic [N_W-1:0]       submat_n;
  logic                 busy;
  logic                 done;
  logic                 start_err;

  modport master (
    output start, submat_m_in, submat_n_in, fill_latency, stall,
    input  wr_en, sub_row, submat_m, submat_n, busy, done, start_err
  );

  modport slave (
    input  start, submat_m_in, submat_n_in, fill_latency, stall,
    output wr_en, sub_row, submat_m, submat_n, busy, done, start_err
  );
endinterface

// File: rtl/accum_wr_sequencer.sv
// rtl/accum_wr_sequencer.sv - steps one sub-matrix of systolic array results into the accumulator table, one row per cycle
module accum_wr_sequencer #(
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int LAT_WIDTH    = 8
) (
  input logic                clk,
  input logic                reset_n,
  accum_wr_sequencer_if.slave bus
);
  localparam int NUM_SUBMATS_M = MAX_OUT_ROWS / SYS_ARR_ROWS;
  localparam int NUM_SUBMATS_N = MAX_OUT_COLS / SYS_ARR_COLS;
  localparam int M_W           = $clog2(NUM_SUBMATS_M);
  localparam int N_W           = $clog2(NUM_SUBMATS_N);
  localparam int ROW_W         = $clog2(SYS_ARR_ROWS);
  localparam logic [ROW_W-1:0]     LAST_ROW = ROW_W'(SYS_ARR_ROWS - 1);
  localparam logic [LAT_WIDTH-1:0] LAT_ONE  = LAT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;

  state_t               state_q, state_d;
  logic [LAT_WIDTH-1:0] lat_q, lat_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [M_W-1:0]       m_q, m_d;
  logic [N_W-1:0]       n_q, n_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
      row_q   <= '0;
      m_q     <= '0;
      n_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      row_q   <= row_d;
      m_q     <= m_d;
      n_q     <= n_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    row_d   = row_q;
    m_d     = m_q;
    n_d     = n_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = bus.submat_m_in;
          n_d     = bus.submat_n_in;
          lat_d   = bus.fill_latency;
          row_d   = '0;
          state_d = (bus.fill_latency != '0) ? WAIT : WRITE;
        end
      end
      WAIT: begin
        // The array pipeline keeps filling under stall, so the countdown ignores it.
        err_d = bus.start;
        lat_d = lat_q - LAT_ONE;
        if (lat_q == LAT_ONE) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        err_d = bus.start;
        if (!bus.stall) begin
          if (row_q == LAST_ROW) begin
            state_d = IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Async reset drives state_q to IDLE at once, which also kills wr_en and busy.
  assign bus.wr_en     = (state_q == WRITE) & ~bus.stall;
  assign bus.busy      = (state_q != IDLE);
  assign bus.sub_row   = row_q;
  assign bus.submat_m  = m_q;
  assign bus.submat_n  = n_q;
  assign bus.done      = done_q;
  assign bus.start_err = err_q;
endmodule

// File: tb/tb_accum_wr_sequencer.sv
// tb/tb_accum_wr_sequencer.sv - randomized trace against a schedule model, plus directed collision/stall/reset cases
module tb_accum_wr_sequencer;
  localparam int N  = 400;
  localparam int NA = N + 64;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  accum_wr_sequencer_if bus ();

  accum_wr_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  bit st_a[NA];
  bit sl_a[NA];
  int lat_a[NA], m_a[NA], n_a[NA];
  bit e_wr[NA], e_busy[NA], e_done[NA], e_err[NA];
  int e_row[NA], e_m[NA], e_n[NA];

  int cyc = 0;
  bit trace_on = 1'b0;
  int busy_cnt = 0;

  task automatic check(input string name, input int c, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  task automatic set_start(input int k, input int m, input int n, input int lat);
    st_a[k]  = 1'b1;
    m_a[k]   = m;
    n_a[k]   = n;
    lat_a[k] = lat;
  endtask

  // Each accepted start expands into a whole timeline: lat wait cycles, then
  // rows placed only on unstalled cycles, then a done cycle where a new start may land.
  task automatic build_model();
    int free_at;
    free_at = 0;
    for (int k = 0; k < NA; k++) begin
      e_wr[k] = 0; e_busy[k] = 0; e_done[k] = 0; e_err[k] = 0;
      e_row[k] = 0; e_m[k] = 0; e_n[k] = 0;
    end
    for (int k = 0; k < N; k++) begin
      if (st_a[k]) begin
        if (k >= free_at) begin
          int j;
          int rows;
          j = k + 1 + lat_a[k];
          rows = 0;
          for (int c = k + 1; c < j; c++) e_busy[c] = 1;
          while (rows < 16) begin
            e_busy[j] = 1;
            e_row[j]  = rows;
            if (!sl_a[j]) begin
              e_wr[j] = 1;
              rows++;
            end
            j++;
          end
          e_done[j] = 1;
          free_at = j;
          for (int c = k + 1; c < NA; c++) begin
            e_m[c] = m_a[k];
            e_n[c] = n_a[k];
          end
        end else begin
          e_err[k + 1] = 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (trace_on) begin
      check("wr_en",     cyc, bus.wr_en,     e_wr[cyc]);
      check("sub_row",   cyc, bus.sub_row,   e_row[cyc]);
      check("submat_m",  cyc, bus.submat_m,  e_m[cyc]);
      check("submat_n",  cyc, bus.submat_n,  e_n[cyc]);
      check("busy",      cyc, bus.busy,      e_busy[cyc]);
      check("done",      cyc, bus.done,      e_done[cyc]);
      check("start_err", cyc, bus.start_err, e_err[cyc]);
      case (cyc)
        5:  check("lit_collision_err", cyc, bus.start_err, 1);
        6:  begin
              check("lit_first_wr", cyc, bus.wr_en, 1);
              check("lit_keep_m", cyc, bus.submat_m, 2);
              check("lit_keep_n", cyc, bus.submat_n, 5);
            end
        21: check("lit_last_row", cyc, bus.sub_row, 15);
        22: check("lit_done_basic", cyc, bus.done, 1);
        23: begin
              check("lit_done_cycle_no_err", cyc, bus.start_err, 0);
              check("lit_done_cycle_accept", cyc, bus.wr_en, 1);
              check("lit_new_m", cyc, bus.submat_m, 1);
            end
        31: begin
              check("lit_stall_wr", cyc, bus.wr_en, 0);
              check("lit_stall_row", cyc, bus.sub_row, 7);
            end
        34: begin
              check("lit_resume_wr", cyc, bus.wr_en, 1);
              check("lit_resume_row", cyc, bus.sub_row, 7);
            end
        43: check("lit_done_delayed", cyc, bus.done, 1);
        56: begin
              check("lit_wait_stall_busy", cyc, bus.busy, 1);
              check("lit_wait_stall_wr", cyc, bus.wr_en, 0);
            end
        58: begin
              check("lit_wait_stall_resume", cyc, bus.wr_en, 1);
              check("lit_wait_stall_row", cyc, bus.sub_row, 0);
            end
        74: check("lit_done_wait_stall", cyc, bus.done, 1);
        81: check("lit_zero_lat_wr", cyc, bus.wr_en, 1);
        97: check("lit_zero_lat_done", cyc, bus.done, 1);
        default: ;
      endcase
      if (cyc >= 78 && cyc <= 99) busy_cnt += int'(bus.busy);
    end
  end

  initial begin
    bit found;
    bit saw_activity;
    found = 1'b0;
    saw_activity = 1'b0;
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.fill_latency = '0;
    bus.submat_m_in = '0;
    bus.submat_n_in = '0;

    for (int k = 0; k < NA; k++) begin
      st_a[k] = 0; sl_a[k] = 0; lat_a[k] = 0; m_a[k] = 0; n_a[k] = 0;
    end
    set_start(2, 2, 5, 3);
    set_start(4, 0, 7, 2);
    set_start(22, 1, 3, 0);
    for (int k = 30; k <= 33; k++) sl_a[k] = 1;
    set_start(50, 3, 1, 5);
    for (int k = 51; k <= 57; k++) sl_a[k] = 1;
    set_start(80, 6, 4, 0);
    for (int k = 100; k < N - 80; k++) begin
      st_a[k]  = ($urandom_range(0, 5) == 0);
      sl_a[k]  = ($urandom_range(0, 4) == 0);
      lat_a[k] = $urandom_range(0, 7);
      m_a[k]   = $urandom_range(0, 7);
      n_a[k]   = $urandom_range(0, 7);
    end
    build_model();

    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", -1, bus.wr_en, 0);
    check("rst_busy", -1, bus.busy, 0);
    check("rst_done", -1, bus.done, 0);
    check("rst_err", -1, bus.start_err, 0);
    check("rst_row", -1, bus.sub_row, 0);
    check("rst_m", -1, bus.submat_m, 0);
    check("rst_n", -1, bus.submat_n, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      #1;
      cyc = k;
      bus.start = st_a[k];
      bus.stall = sl_a[k];
      bus.fill_latency = 8'(lat_a[k]);
      bus.submat_m_in = 3'(m_a[k]);
      bus.submat_n_in = 3'(n_a[k]);
      trace_on = 1'b1;
    end
    @(posedge clk);
    #1;
    trace_on = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    check("zero_lat_busy_cycles", 80, busy_cnt, 16);

    bus.start = 1'b1;
    bus.fill_latency = 8'd0;
    bus.submat_m_in = 3'd4;
    bus.submat_n_in = 3'd6;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.sub_row == 4'd9) found = 1'b1;
    end
    check("reach_row9", N, found, 1);
    check("row9_writing", N, bus.wr_en, 1);
    reset_n = 1'b0;
    #1;
    check("arst_wr_en", N, bus.wr_en, 0);
    check("arst_busy", N, bus.busy, 0);
    check("arst_row", N, bus.sub_row, 0);
    check("arst_m", N, bus.submat_m, 0);
    check("arst_n", N, bus.submat_n, 0);
    check("arst_done", N, bus.done, 0);
    check("arst_err", N, bus.start_err, 0);

    bus.start = 1'b1;
    bus.submat_m_in = 3'd5;
    bus.submat_n_in = 3'd2;
    repeat (3) begin
      @(negedge clk);
      if (bus.busy || bus.done || bus.wr_en) saw_activity = 1'b1;
    end
    check("start_ignored_in_reset", N, saw_activity, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", N, bus.busy, 1);
    check("post_rst_wr_en", N, bus.wr_en, 1);
    check("post_rst_row", N, bus.sub_row, 0);
    check("post_rst_m", N, bus.submat_m, 5);
    check("post_rst_n", N, bus.submat_n, 2);
    check("post_rst_err", N, bus.start_err, 0);
    bus.start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/accum_wr_sequencer.md
ACCUM_WR_SEQUENCER -- requirements
Module: accum_wr_sequencer

Interface
REQ-001 SHALL have parameter SYS_ARR_ROWS, default 16: systolic array rows, which is also the number of result rows per sub-matrix.
REQ-002 SHALL have parameter SYS_ARR_COLS, default 16: systolic array columns; it sets NUM_SUBMATS_N only.
REQ-003 SHALL have parameter MAX_OUT_ROWS, default 128, and parameter MAX_OUT_COLS, default 128: the output matrix bounds.
REQ-004 SHALL have parameter LAT_WIDTH, default 8: the width of fill_latency.
REQ-005 SHALL derive localparams NUM_SUBMATS_M = MAX_OUT_ROWS/SYS_ARR_ROWS and NUM_SUBMATS_N = MAX_OUT_COLS/SYS_ARR_COLS.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: a one-cycle request to sequence one sub-matrix.
REQ-009 SHALL have port submat_m_in, input, $clog2(NUM_SUBMATS_M) bits: the sub-matrix row coordinate, sampled at an accepted start.
REQ-010 SHALL have port submat_n_in, input, $clog2(NUM_SUBMATS_N) bits: the sub-matrix column coordinate, sampled at an accepted start.
REQ-011 SHALL have port fill_latency, input, LAT_WIDTH bits: the cycles between start acceptance and the first valid array row, sampled at an accepted start.
REQ-012 SHALL have port stall, input, 1 bit: holds sequencing; no write occurs in a cycle where it is high.
REQ-013 SHALL have port wr_en, output, 1 bit: the write enable for column 0, feeding the accumulator-table write controller wr_en_in.
REQ-014 SHALL have port sub_row, output, $clog2(SYS_ARR_ROWS) bits: the row within the sub-matrix being written.
REQ-015 SHALL have port submat_m, output, $clog2(NUM_SUBMATS_M) bits: the latched sub-matrix row coordinate.
REQ-016 SHALL have port submat_n, output, $clog2(NUM_SUBMATS_N) bits: the latched sub-matrix column coordinate.
REQ-017 SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-018 SHALL have port done, output, 1 bit: a one-cycle pulse after the final row is written.
REQ-019 SHALL have port start_err, output, 1 bit: a one-cycle pulse when start arrives while busy.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT, and WRITE.
REQ-021 SHALL, in IDLE with start=1, latch submat_m_in, submat_n_in, and fill_latency, and clear sub_row to 0.
REQ-022 SHALL then go to WAIT if fill_latency>0, else go directly to WRITE.
REQ-023 SHALL, in WAIT, decrement a latency counter each cycle, unaffected by stall, and go to WRITE after exactly fill_latency WAIT cycles.
REQ-024 SHALL produce wr_en = (state==WRITE) & ~stall combinationally; every other output SHALL be registered.
REQ-025 SHALL, in WRITE with stall=0, increment sub_row; stall=1 SHALL hold sub_row and the state.
REQ-026 SHALL, on a write with sub_row==SYS_ARR_ROWS-1, go to IDLE, return sub_row to 0, and set done=1 for the next cycle only.
REQ-027 SHALL never let sub_row wrap within one sequence.
REQ-028 SHALL meet this latency: with start accepted at edge T, the first wr_en is high in the cycle after edge T+fill_latency, assuming no stall.
REQ-029 SHALL give SYS_ARR_ROWS+fill_latency busy cycles per sequence when there is no stall.
REQ-030 SHALL, on start while busy, ignore the start and pulse start_err for one cycle; the latched coordinates and state SHALL be unchanged.
REQ-031 SHALL accept a start in the cycle done is high, because the state is IDLE then; back-to-back sequences have no dead cycle beyond the done cycle.
REQ-032 SHALL hold submat_m and submat_n stable from acceptance until the next accepted start; they remain valid in IDLE.

Reset
REQ-033 SHALL, on reset_n=0 asynchronously, force state=IDLE, sub_row=0, submat_m=0, submat_n=0, latency counter=0, busy=0, done=0, start_err=0.
REQ-034 SHALL force wr_en=0 while reset_n=0.
REQ-035 SHALL abandon a sequence on reset mid-sequence: no done pulse is issued and no further writes occur.
REQ-036 SHALL ignore start while reset_n=0; after release, the first rising edge with start=1 is accepted.

Verification
REQ-037 SHALL cover basic: start with m=2, n=5, fill_latency=3 -> 3 WAIT cycles, then 16 consecutive wr_en cycles with sub_row 0..15, submat_m=2 and submat_n=5 throughout, and done one cycle after sub_row 15.
REQ-038 SHALL cover zero latency: fill_latency=0 -> wr_en high in the cycle after start, and busy for exactly 16 cycles.
REQ-039 SHALL cover stall: stall held high for 4 cycles while sub_row=7 -> wr_en low for those 4 cycles, sub_row held at 7, writing resuming at 7, and done delayed by 4 cycles.
REQ-040 SHALL cover collision: start during WAIT with m=0 -> start_err pulse, outputs keep the original m, and the sequence completes normally; start on the done cycle -> accepted with no start_err.
REQ-041 SHALL cover reset: reset_n low while sub_row=9 -> wr_en=0 and busy=0 immediately without waiting for a clock edge, no done pulse, and all outputs at zero.
REQ-042 SHALL cover stall in WAIT: stall high throughout WAIT with fill_latency=5 -> WRITE is still entered after 5 cycles, and wr_en stays low until stall drops.
